// File: rtl/data_mem_if.sv
// Request/response bundle between the processor memory stage and data_mem_unit.
interface data_mem_if;
    logic        req;
    logic [7:0]  mem_op;
    logic [31:0] mem_addr;
    logic [31:0] mem_data_in;
    logic [31:0] mem_data_out;
    logic        busy;
    logic        done;
    logic        fault;
    logic [1:0]  fault_code;

    modport master (
        output req, mem_op, mem_addr, mem_data_in,
        input  mem_data_out, busy, done, fault, fault_code
    );

    modport slave (
        input  req, mem_op, mem_addr, mem_data_in,
        output mem_data_out, busy, done, fault, fault_code
    );
endinterface

// File: rtl/data_mem_unit.sv
// Memory stage: fetch plus RV32I loads/stores on a synchronous single-port word RAM,
// with alignment/range checks, lane select, extension and read-modify-write sub-word stores.
module data_mem_unit #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter string       INIT_FILE   = ""
) (
    input logic         clk,
    input logic         rst,
    data_mem_if.slave   bus
);
    localparam int unsigned AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

    localparam logic [3:0] OpFetch = 4'd1;
    localparam logic [3:0] OpLb    = 4'd2;
    localparam logic [3:0] OpLh    = 4'd3;
    localparam logic [3:0] OpLw    = 4'd4;
    localparam logic [3:0] OpLbu   = 4'd5;
    localparam logic [3:0] OpLhu   = 4'd6;
    localparam logic [3:0] OpSb    = 4'd7;
    localparam logic [3:0] OpSh    = 4'd8;
    localparam logic [3:0] OpSw    = 4'd9;

    typedef enum logic [2:0] {StIdle, StRd, StFmt, StMerge, StWr, StDone} state_e;

    state_e      state_q, state_d;
    logic [31:0] ram [DEPTH_WORDS];
    logic [3:0]  op_q;
    logic [AW-1:0] word_q;
    logic [1:0]  lane_q;
    logic [31:0] data_q;
    logic [31:0] rdata_q;
    logic [31:0] dout_q;
    logic        fault_q;
    logic [1:0]  code_q;

    logic        accept;
    logic [3:0]  req_op;
    logic [1:0]  chk_code;
    logic [31:0] formatted;
    logic [31:0] merged;
    logic        ram_we;
    logic [31:0] ram_wdata;

    assign req_op = bus.mem_op[3:0];
    assign accept = (state_q == StIdle) && bus.req && (bus.mem_op != 8'd0);

    // Acceptance checks in priority order: illegal op, misalignment, range.
    always_comb begin
        chk_code = 2'd0;
        if (bus.mem_op > 8'd9) begin
            chk_code = 2'd3;
        end else if (((req_op == OpFetch || req_op == OpLw || req_op == OpSw) &&
                      bus.mem_addr[1:0] != 2'b00) ||
                     ((req_op == OpLh || req_op == OpLhu || req_op == OpSh) &&
                      bus.mem_addr[0])) begin
            chk_code = 2'd1;
        end else if ({2'b00, bus.mem_addr[31:2]} >= DEPTH_WORDS) begin
            chk_code = 2'd2;
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= StIdle;
        else      state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle: begin
                if (accept) begin
                    if (chk_code != 2'd0)   state_d = StDone;
                    else if (req_op == OpSw) state_d = StWr;
                    else                     state_d = StRd;
                end
            end
            StRd:    state_d = (op_q == OpSb || op_q == OpSh) ? StMerge : StFmt;
            StFmt:   state_d = StDone;
            StMerge: state_d = StDone;
            StWr:    state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Output / RAM control logic
    always_comb begin
        ram_we    = (state_q == StWr) || (state_q == StMerge);
        ram_wdata = (state_q == StWr) ? data_q : merged;
    end

    assign bus.busy         = (state_q != StIdle);
    assign bus.done         = (state_q == StDone);
    assign bus.fault        = fault_q;
    assign bus.fault_code   = code_q;
    assign bus.mem_data_out = dout_q;

    always_comb begin
        logic [7:0]  sel_byte;
        logic [15:0] sel_half;
        sel_byte = rdata_q[8*lane_q +: 8];
        sel_half = lane_q[1] ? rdata_q[31:16] : rdata_q[15:0];
        case (op_q)
            OpLb:    formatted = {{24{sel_byte[7]}}, sel_byte};
            OpLbu:   formatted = {24'd0, sel_byte};
            OpLh:    formatted = {{16{sel_half[15]}}, sel_half};
            OpLhu:   formatted = {16'd0, sel_half};
            default: formatted = rdata_q;
        endcase
    end

    // Only the addressed lane is replaced; the remaining bytes come from the RAM read.
    always_comb begin
        merged = rdata_q;
        if (op_q == OpSb)    merged[8*lane_q +: 8] = data_q[7:0];
        else if (lane_q[1])  merged[31:16] = data_q[15:0];
        else                 merged[15:0]  = data_q[15:0];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            op_q    <= 4'd0;
            word_q  <= '0;
            lane_q  <= 2'd0;
            data_q  <= 32'd0;
            fault_q <= 1'b0;
            code_q  <= 2'd0;
            dout_q  <= 32'd0;
        end else begin
            if (accept) begin
                op_q    <= req_op;
                word_q  <= bus.mem_addr[AW+1:2];
                lane_q  <= bus.mem_addr[1:0];
                data_q  <= bus.mem_data_in;
                fault_q <= (chk_code != 2'd0);
                code_q  <= chk_code;
            end
            if (state_q == StFmt) dout_q <= formatted;
        end
    end

    // RAM is not reset; a write only happens from StWr/StMerge, which reset leaves at once.
    always_ff @(posedge clk) begin
        if (ram_we) ram[word_q] <= ram_wdata;
        rdata_q <= ram[word_q];
    end
endmodule

// File: tb/tb_data_mem_unit.sv
// Scoreboard bench for data_mem_unit: driver queues expected completions, monitor checks on done.
module tb_data_mem_unit;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    data_mem_if bus();

    data_mem_unit #(.DEPTH_WORDS(1024), .INIT_FILE("")) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        int          id;
        logic        f;
        logic [1:0]  c;
        logic [31:0] d;
        int          due;
    } exp_t;

    exp_t sb[$];
    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    // Monitor: cycle counter advances on every falling edge, done is sampled there too.
    always @(negedge clk) begin : monitor
        exp_t e;
        cyc = cyc + 1;
        if (bus.done === 1'b1) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_done: got done at cycle %0d expected none", cyc);
            end else begin
                e = sb.pop_front();
                check($sformatf("op%0d_fault", e.id), 32'(bus.fault), 32'(e.f));
                check($sformatf("op%0d_code", e.id), 32'(bus.fault_code), 32'(e.c));
                check($sformatf("op%0d_data", e.id), bus.mem_data_out, e.d);
                check($sformatf("op%0d_latency", e.id), 32'(cyc), 32'(e.due));
            end
        end
    end

    task automatic wait_idle();
        int n = 0;
        @(negedge clk);
        #1;
        while (bus.busy !== 1'b0 && n < 50) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (n >= 50) begin
            total++;
            bad++;
            $display("FAIL wait_idle: busy=%b expected 0 within 50 cycles", bus.busy);
        end
    endtask

    task automatic drive(input int id, input logic [7:0] op, input logic [31:0] addr,
                         input logic [31:0] data, input int lat, input logic f,
                         input logic [1:0] c, input logic [31:0] d);
        exp_t e;
        wait_idle();
        bus.req         = 1'b1;
        bus.mem_op      = op;
        bus.mem_addr    = addr;
        bus.mem_data_in = data;
        e.id  = id;
        e.f   = f;
        e.c   = c;
        e.d   = d;
        e.due = cyc + lat;
        sb.push_back(e);
        @(posedge clk);
    endtask

    task automatic issue(input int id, input logic [7:0] op, input logic [31:0] addr,
                         input logic [31:0] data, input int lat, input logic f,
                         input logic [1:0] c, input logic [31:0] d);
        drive(id, op, addr, data, lat, f, c, d);
        #1;
        bus.req = 1'b0;
    endtask

    initial begin
        int n;
        bus.req = 1'b0;
        bus.mem_op = 8'd0;
        bus.mem_addr = 32'd0;
        bus.mem_data_in = 32'd0;
        #12;
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_fault", 32'(bus.fault), 32'd0);
        check("rst_code", 32'(bus.fault_code), 32'd0);
        check("rst_data", bus.mem_data_out, 32'd0);
        @(negedge clk);
        rst = 1'b1;

        //     id op     addr          data          lat f  c  expected mem_data_out
        issue(1,  8'd9,  32'h0000_0000, 32'h55AA55AA, 2, 0, 0, 32'h0000_0000);
        issue(2,  8'd9,  32'h0000_0010, 32'hDEADBEEF, 2, 0, 0, 32'h0000_0000);
        issue(3,  8'd4,  32'h0000_0010, 32'h0,        3, 0, 0, 32'hDEADBEEF);
        issue(4,  8'd2,  32'h0000_0013, 32'h0,        3, 0, 0, 32'hFFFFFFDE);
        issue(5,  8'd5,  32'h0000_0013, 32'h0,        3, 0, 0, 32'h000000DE);
        issue(6,  8'd3,  32'h0000_0010, 32'h0,        3, 0, 0, 32'hFFFFBEEF);
        issue(7,  8'd6,  32'h0000_0012, 32'h0,        3, 0, 0, 32'h0000DEAD);
        issue(8,  8'd7,  32'h0000_0011, 32'h12345678, 3, 0, 0, 32'h0000DEAD);
        issue(9,  8'd8,  32'h0000_0012, 32'h0000CAFE, 3, 0, 0, 32'h0000DEAD);
        issue(10, 8'd4,  32'h0000_0010, 32'h0,        3, 0, 0, 32'hCAFE78EF);
        issue(11, 8'd4,  32'h0000_0002, 32'h0,        1, 1, 1, 32'hCAFE78EF);
        issue(12, 8'd9,  32'h0000_1000, 32'hFFFFFFFF, 1, 1, 2, 32'hCAFE78EF);
        issue(13, 8'd4,  32'h0000_0000, 32'h0,        3, 0, 0, 32'h55AA55AA);
        issue(14, 8'd12, 32'h0000_0003, 32'h0,        1, 1, 3, 32'h55AA55AA);
        issue(15, 8'd3,  32'h0000_0011, 32'h0,        1, 1, 1, 32'h55AA55AA);
        issue(16, 8'd4,  32'h0000_1002, 32'h0,        1, 1, 1, 32'h55AA55AA);
        issue(17, 8'd9,  32'h0000_0FFC, 32'h0BADF00D, 2, 0, 0, 32'h55AA55AA);
        issue(18, 8'd2,  32'h0000_0FFF, 32'h0,        3, 0, 0, 32'h0000000B);
        issue(19, 8'd1,  32'h0000_0010, 32'h0,        3, 0, 0, 32'hCAFE78EF);
        issue(20, 8'd3,  32'h0000_0012, 32'h0,        3, 0, 0, 32'hFFFFCAFE);
        issue(21, 8'd2,  32'h0000_0011, 32'h0,        3, 0, 0, 32'h00000078);

        // req stays high with a store to the same word through the whole busy window.
        drive(22, 8'd4, 32'h0000_0010, 32'h0, 3, 0, 0, 32'hCAFE78EF);
        #1;
        bus.mem_op = 8'd9;
        bus.mem_data_in = 32'h0;
        repeat (4) @(negedge clk);
        bus.req = 1'b0;
        issue(23, 8'd4, 32'h0000_0010, 32'h0, 3, 0, 0, 32'hCAFE78EF);

        wait_idle();
        bus.req = 1'b1;
        bus.mem_op = 8'd0;
        @(negedge clk);
        #1;
        check("nop_busy_1", 32'(bus.busy), 32'd0);
        @(negedge clk);
        #1;
        check("nop_busy_2", 32'(bus.busy), 32'd0);
        bus.req = 1'b0;

        issue(24, 8'd9, 32'h0000_0020, 32'h11223344, 2, 0, 0, 32'hCAFE78EF);

        // Abort an SB while it sits in RD.
        wait_idle();
        bus.req = 1'b1;
        bus.mem_op = 8'd7;
        bus.mem_addr = 32'h0000_0020;
        bus.mem_data_in = 32'h000000AA;
        @(posedge clk);
        #1;
        bus.req = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("abort_busy", 32'(bus.busy), 32'd0);
        check("abort_done", 32'(bus.done), 32'd0);
        check("abort_fault", 32'(bus.fault), 32'd0);
        check("abort_data", bus.mem_data_out, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;

        issue(25, 8'd4, 32'h0000_0020, 32'h0,        3, 0, 0, 32'h11223344);
        issue(26, 8'd7, 32'h0000_0023, 32'h00000099, 3, 0, 0, 32'h11223344);
        issue(27, 8'd4, 32'h0000_0020, 32'h0,        3, 0, 0, 32'h99223344);

        n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain: got %0d pending completions expected 0", sb.size());
        end
        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
